// File: rtl/multiplicador_pkg.sv
// multiplicador_pkg: shared state encoding and default operand width for the shift-and-add multiplier.
package multiplicador_pkg;
  localparam int W_DEFAULT = 3;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/registro_desplazamiento.sv
// registro_desplazamiento: loadable shift register, one-bit logical shift left or right per enabled cycle.
module registro_desplazamiento #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic         i_right,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_q <= '0;
    else r_q <= i_load ? i_d : i_shift ? (i_right ? r_q >> 1 : r_q << 1) : r_q;
  assign o_q = r_q;
endmodule

// File: rtl/multiplicador.sv
// multiplicador: sequential unsigned shift-and-add multiplier, W x W -> 2W bits.
// Defining MULTIPLICADOR_DEBUG_EN exposes testState, testPP and testB.
module multiplicador
  import multiplicador_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   MD,
  input  logic [W-1:0]   MR,
  input  logic           start,
  output logic [2*W-1:0] resultado,
  output logic           done
`ifdef MULTIPLICADOR_DEBUG_EN
  ,
  output logic [2:0]     testState,
  output logic [2*W-1:0] testPP,
  output logic [W-1:0]   testB
`endif
);
  state_t r_state, w_next;
  logic [2*W-1:0] w_a, r_pp, r_res;
  logic [W-1:0] w_b;
  logic w_load, w_shift;
  assign w_load  = (r_state == IDLE) && start;
  assign w_shift = (r_state == SHIFT);
  registro_desplazamiento #(.W(2*W)) u_a (
    .clk(clk), .rst_n(rst_n), .i_load(w_load), .i_shift(w_shift), .i_right(1'b0),
    .i_d({{W{1'b0}}, MD}), .o_q(w_a)
  );
  registro_desplazamiento #(.W(W)) u_b (
    .clk(clk), .rst_n(rst_n), .i_load(w_load), .i_shift(w_shift), .i_right(1'b1),
    .i_d(MR), .o_q(w_b)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? CHECK : IDLE;
      CHECK:   w_next = (w_b == '0) ? DONE : w_b[0] ? ADD : SHIFT;
      ADD:     w_next = SHIFT;
      SHIFT:   w_next = CHECK;
      DONE:    w_next = start ? DONE : IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_pp    <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_next;
      r_pp    <= w_load ? '0 : (r_state == ADD) ? r_pp + w_a : r_pp;
      r_res   <= (r_state == CHECK && w_b == '0) ? r_pp : r_res;
    end
  assign resultado = r_res;
  assign done      = (r_state == DONE);
`ifdef MULTIPLICADOR_DEBUG_EN
  assign testState = r_state;
  assign testPP    = r_pp;
  assign testB     = w_b;
`endif
endmodule

// File: tb/tb_multiplicador.sv
// tb_multiplicador: scoreboard bench comparing product and latency against an arithmetic reference model.
`timescale 1ns/100ps
module tb_multiplicador;
  localparam int W = 3;
  typedef struct {
    logic [2*W-1:0] res;
    int             lat;
    int             load;
  } exp_t;
  logic clk = 0, rst_n = 0, start = 0, done;
  logic [W-1:0] MD = '0, MR = '0;
  logic [2*W-1:0] resultado;
  int errors = 0, checks = 0, cyc = 0;
  logic prev_done = 0;
  logic [2*W-1:0] last_res = '0;
  exp_t sb[$];
  multiplicador #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .MD(MD), .MR(MR), .start(start),
    .resultado(resultado), .done(done)
  );
  always #1 clk = ~clk;
  always @(posedge clk) cyc++;
  function automatic int lat_of(int mr);
    int s = 2;
    for (int i = 0; i < W; i++) if ((mr >> i) != 0) s += 2 + ((mr >> i) & 1);
    return s;
  endfunction
  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask
  always @(negedge clk) begin
    if (done && !prev_done) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("resultado", int'(resultado), int'(e.res));
        chk("latency", cyc - e.load + 1, e.lat);
      end
    end
    prev_done = done;
  end
  task automatic launch(input int md, input int mr, input bit hold);
    exp_t e;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    MD = W'(md);
    MR = W'(mr);
    start = 1;
    @(posedge clk);
    #0.1;
    chk("held_at_load", int'(resultado), int'(last_res));
    e.res = (2*W)'(md * mr);
    e.lat = lat_of(mr);
    e.load = cyc;
    sb.push_back(e);
    start = hold;
  endtask
  task automatic finish_op();
    int i;
    for (i = 0; i < 60 && !done; i++) @(negedge clk);
    if (!done) chk("done_timeout", 0, 1);
    last_res = resultado;
  endtask
  task automatic run(input int md, input int mr, input bit hold, input bit chg);
    launch(md, mr, hold);
    if (chg) begin
      @(posedge clk);
      @(posedge clk);
      #0.1;
      MD = 3'd7;
      MR = 3'd7;
    end
    finish_op();
  endtask
  initial begin
    #0.5;
    chk("reset_res", int'(resultado), 0);
    chk("reset_done", int'(done), 0);
    #9.5 rst_n = 1;
    run(5, 1, 0, 0);
    run(7, 7, 0, 0);
    run(5, 3, 0, 0);
    run(6, 0, 0, 0);
    run(0, 4, 0, 0);
    run(6, 5, 1, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_done", int'(done), 1);
      chk("hold_res", int'(resultado), 30);
    end
    chk("no_extra_op", sb.size(), 0);
    run(3, 2, 0, 0);
    run(2, 3, 0, 1);
    launch(6, 7, 0);
    @(posedge clk);
    @(posedge clk);
    #0.5 rst_n = 0;
    #0.2;
    void'(sb.pop_back());
    chk("rst_res", int'(resultado), 0);
    chk("rst_done", int'(done), 0);
    last_res = '0;
    @(negedge clk);
    rst_n = 1;
    run(4, 5, 0, 0);
    for (int i = 0; i < 40; i++) run($urandom_range(0, 7), $urandom_range(0, 7), 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
